// File: rtl/string_hw_pkg.sv
// Shared definitions for the string FIFO accelerator: register map, pop modes, STATUS bit
// positions and the per-byte case transform.
package string_hw_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_THRESH = 3'd4;

  typedef enum logic [1:0] {MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_REV} mode_e;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UDF   = 3;

  // Case conversion of one ASCII byte; byte reversal is a lane permutation done by the caller.
  function automatic logic [7:0] byte_xform(input logic [7:0] data, input mode_e mode);
    logic [7:0] r;
    r = data;
    case (mode)
      MODE_UPPER: if (data >= 8'h61 && data <= 8'h7A) r = data - 8'h20;
      MODE_LOWER: if (data >= 8'h41 && data <= 8'h5A) r = data + 8'h20;
      default:    r = data;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/string_fifo_avalon_if.sv
// Avalon-MM slave bus plus level interrupt of the string FIFO.
interface string_fifo_avalon_if #(parameter int DATA_W = 32);
  logic              chipselect;
  logic [2:0]        address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master(output chipselect, address, write, writedata, read, input readdata, irq);
  modport slave (input chipselect, address, write, writedata, read, output readdata, irq);
endinterface

// File: rtl/string_fifo_core.sv
// Word FIFO with a combinational head output, separate occupancy count and synchronous clear.
module string_fifo_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk)
    if (push && !full && !clear) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push && !full, pop && !empty})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/string_fifo_avalon.sv
// Avalon-MM register front-end for the string FIFO: decode, CTRL/THRESH, sticky flags,
// transformed pop data and the level-threshold interrupt.
module string_fifo_avalon
  import string_hw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  string_fifo_avalon_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              wr_acc, rd_acc, is_data;
  logic              push, pop, clear, full, empty;
  logic [DATA_W-1:0] dout, xdata, rdata_nxt, readdata;
  logic [CNT_W-1:0]  count, thresh;
  mode_e             mode;
  logic              irq_en, ovf, udf, irq;

  // A write beats a simultaneous read; the read half is dropped entirely.
  assign wr_acc  = bus.chipselect & bus.write;
  assign rd_acc  = bus.chipselect & bus.read & ~bus.write;
  assign is_data = (bus.address == ADDR_DATA);
  assign push    = wr_acc & is_data;
  assign pop     = rd_acc & is_data;
  assign clear   = wr_acc & (bus.address == ADDR_CTRL) & bus.writedata[3];

  string_fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_core (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .clear(clear),
    .din(bus.writedata), .dout(dout), .count(count), .full(full), .empty(empty)
  );

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign xdata[8*g +: 8] = (mode == MODE_REV) ? dout[8*(NB-1-g) +: 8]
                                                : byte_xform(dout[8*g +: 8], mode);
  end

  always_comb begin
    rdata_nxt = '0;
    if (rd_acc) begin
      case (bus.address)
        ADDR_DATA:   if (!empty) rdata_nxt = xdata;
        ADDR_CTRL:   rdata_nxt[2:0] = {irq_en, mode};
        ADDR_COUNT:  rdata_nxt[CNT_W-1:0] = count;
        ADDR_STATUS: rdata_nxt[3:0] = {udf, ovf, full, empty};
        ADDR_THRESH: rdata_nxt[CNT_W-1:0] = thresh;
        default:     rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode     <= MODE_PASS;
      irq_en   <= 1'b0;
      thresh   <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rdata_nxt;
      irq      <= irq_en && (count >= thresh) && (thresh != '0);
      if (wr_acc) begin
        case (bus.address)
          ADDR_CTRL: begin
            mode   <= mode_e'(bus.writedata[1:0]);
            irq_en <= bus.writedata[2];
          end
          ADDR_STATUS: begin
            if (bus.writedata[ST_OVF]) ovf <= 1'b0;
            if (bus.writedata[ST_UDF]) udf <= 1'b0;
          end
          ADDR_THRESH: thresh <= bus.writedata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (push && full)  ovf <= 1'b1;
      if (pop  && empty) udf <= 1'b1;
    end
  end

  assign bus.readdata = readdata;
  assign bus.irq      = irq;
endmodule

// File: tb/tb_string_fifo_avalon.sv
// Scenario bench for string_fifo_avalon: register reads against constants, pop data against
// a scoreboard filled at push time by an independent transform model.
module tb_string_fifo_avalon;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  string_fifo_avalon_if #(.DATA_W(DATA_W)) bus ();

  string_fifo_avalon #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur_mode = 0;
  logic [31:0] sb[$];
  logic [31:0] d, e;

  function automatic logic [31:0] model(input logic [31:0] w, input int m);
    logic [31:0] r;
    logic [7:0]  b;
    if (m == 3) return {w[7:0], w[15:8], w[23:16], w[31:24]};
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      if (m == 1 && b inside {[8'h61:8'h7A]}) b = b & 8'hDF;
      if (m == 2 && b inside {[8'h41:8'h5A]}) b = b | 8'h20;
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = v;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    v = bus.readdata;
  endtask

  task automatic push(input logic [31:0] v);
    bus_write(3'd0, v);
    sb.push_back(model(v, cur_mode));
  endtask

  task automatic pop_cmp(input string nm);
    bus_read(3'd0, d);
    e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
    n_cmp++;
    if (d !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, d, e);
    end
  endtask

  task automatic test_reset();
    bus.chipselect = 0; bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin n_bad++;
      $display("FAIL reset_outputs: got rd=%h irq=%b expected 0/0", bus.readdata, bus.irq); end
    reset_n = 1'b1;
    bus_read(3'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %h expected 0", d); end
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL reset_status: got %h expected 1", d); end
    bus_read(3'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL underflow_data: got %h expected 0", d); end
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h9) begin n_bad++; $display("FAIL underflow_status: got %h expected 9", d); end
    bus_write(3'd3, 32'h8);
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL w1c_udf: got %h expected 1", d); end
  endtask

  task automatic test_order();
    logic [31:0] words[4] = '{32'h61626364, 32'h31323334, 32'h35363738, 32'h42454546};
    for (int i = 0; i < 4; i++) begin
      push(words[i]);
      bus_read(3'd2, d);
      n_cmp++; if (d !== 32'(i+1)) begin n_bad++;
        $display("FAIL order_count_up: got %0d expected %0d", d, i+1); end
    end
    for (int i = 0; i < 4; i++) begin
      pop_cmp("order_pop");
      bus_read(3'd2, d);
      n_cmp++; if (d !== 32'(3-i)) begin n_bad++;
        $display("FAIL order_count_down: got %0d expected %0d", d, 3-i); end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) push(32'(i));
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL full_status: got %h expected 2", d); end
    bus_write(3'd0, 32'hDEAD);
    bus_read(3'd2, d);
    n_cmp++; if (d !== 32'd16) begin n_bad++; $display("FAIL ovf_count: got %0d expected 16", d); end
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL ovf_status: got %h expected 6", d); end
    for (int i = 0; i < DEPTH; i++) pop_cmp("full_pop");
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h5) begin n_bad++; $display("FAIL drained_status: got %h expected 5", d); end
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL w1c_ovf: got %h expected 1", d); end
  endtask

  task automatic test_xform();
    cur_mode = 1; bus_write(3'd1, 32'h1); push(32'h6142317A); pop_cmp("upper");
    cur_mode = 2; bus_write(3'd1, 32'h2); push(32'h51774521); pop_cmp("lower");
    cur_mode = 3; bus_write(3'd1, 32'h3); push(32'h11223344); pop_cmp("reverse");
    bus_read(3'd1, d);
    n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL ctrl_readback: got %h expected 3", d); end
    cur_mode = 0; bus_write(3'd1, 32'h0);
  endtask

  task automatic test_irq();
    bus_write(3'd4, 32'd3);
    bus_write(3'd1, 32'h4);
    push(32'hA0); push(32'hA1);
    @(negedge clk);
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL irq_below: got %b expected 0", bus.irq); end
    push(32'hA2);
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b expected 0", bus.irq); end
    @(negedge clk);
    n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise: got %b expected 1", bus.irq); end
    pop_cmp("irq_pop");
    n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold: got %b expected 1", bus.irq); end
    @(negedge clk);
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall: got %b expected 0", bus.irq); end
    push(32'hA3);
    repeat (2) @(negedge clk);
    bus_write(3'd1, 32'h0);
    @(negedge clk);
    n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL irq_disable: got %b expected 0", bus.irq); end
    for (int i = 0; i < 3; i++) pop_cmp("irq_drain");
    bus_write(3'd4, 32'd0);
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 5; i++) push(32'hC0 + 32'(i));
    bus_write(3'd1, 32'h8);
    sb.delete();
    bus_read(3'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL clear_count: got %h expected 0", d); end
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL clear_status: got %h expected 1", d); end
    bus_write(3'd4, 32'd2);
    bus_write(3'd1, 32'h5);
    push(32'h1); push(32'h2); push(32'h3);
    bus_read(3'd1, d);
    n_cmp++; if (bus.irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq: got %b expected 1", bus.irq); end
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 3'd1; bus.writedata = 32'h7;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.irq !== 1'b0 || bus.readdata !== 32'h0) begin n_bad++;
      $display("FAIL async_reset: got irq=%b rd=%h expected 0/0", bus.irq, bus.readdata); end
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
    reset_n = 1'b1;
    sb.delete();
    bus_read(3'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_count: got %h expected 0", d); end
    bus_read(3'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl: got %h expected 0", d); end
    bus_read(3'd4, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_thresh: got %h expected 0", d); end
    bus_read(3'd3, d);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL rst_status: got %h expected 1", d); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_xform();
    test_irq();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
